// File: rtl/alu.sv
// Registered 8-bit ALU: eight unsigned operations selected by ALU_Sel, with the result,
// carry/borrow flag and zero flag all captured together on the rising clock edge.
module alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALU_Sel,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut,
  output logic             zeroFlag
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_SHL = 3'b100,
    OP_SHR = 3'b101,
    OP_AND = 3'b110,
    OP_XOR = 3'b111
  } op_e;

  op_e                op_sel;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   result;
  logic               carry;

  assign op_sel = op_e'(ALU_Sel);

  // The extra top bit of sum/diff is the carry or borrow out of the 8-bit operation.
  always_comb begin
    sum      = {1'b0, A} + {1'b0, B};
    diff     = {1'b0, A} - {1'b0, B};
    product  = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    quotient = '1;
    if (B != '0) begin
      quotient = A / B;
    end
  end

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op_sel)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
      end
      OP_MUL: begin
        result = product[WIDTH-1:0];
        carry  = (product[2*WIDTH-1:WIDTH] != '0);
      end
      // Divide by zero saturates the quotient and raises the flag.
      OP_DIV: begin
        result = quotient;
        carry  = (B == '0);
      end
      OP_SHL: begin
        result = {A[WIDTH-2:0], 1'b0};
        carry  = A[WIDTH-1];
      end
      OP_SHR: begin
        result = {1'b0, A[WIDTH-1:1]};
        carry  = A[0];
      end
      OP_AND: begin
        result = A & B;
        carry  = 1'b0;
      end
      OP_XOR: begin
        result = A ^ B;
        carry  = 1'b0;
      end
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

  // The zero flag is derived from the same result being registered, so it never lags ALU_Out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALU_Out  <= '0;
      CarryOut <= 1'b0;
      zeroFlag <= 1'b0;
    end else begin
      ALU_Out  <= result;
      CarryOut <= carry;
      zeroFlag <= (result == '0);
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: the driver queues hand-computed expectations as it issues each
// operation, and a monitor pops and compares one entry per clock edge.
module tb_alu;

  logic       clk;
  logic       rst;
  logic [7:0] A;
  logic [7:0] B;
  logic [2:0] ALU_Sel;
  logic [7:0] ALU_Out;
  logic       CarryOut;
  logic       zeroFlag;

  typedef struct {
    logic [7:0] out;
    logic       carry;
    logic       zero;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  alu #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .ALU_Sel  (ALU_Sel),
    .ALU_Out  (ALU_Out),
    .CarryOut (CarryOut),
    .zeroFlag (zeroFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] exp_out,
                             input logic exp_carry, input logic exp_zero);
    tests_run++;
    if (ALU_Out !== exp_out || CarryOut !== exp_carry || zeroFlag !== exp_zero) begin
      tests_failed++;
      $display("[TB] FAIL %s: got out=%02h carry=%0b zero=%0b, expected out=%02h carry=%0b zero=%0b",
               name, ALU_Out, CarryOut, zeroFlag, exp_out, exp_carry, exp_zero);
    end
  endtask

  // Inputs change on the falling edge; the result is due after the following rising edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel,
                               input logic [7:0] exp_out, input logic exp_carry,
                               input logic exp_zero, input string name);
    exp_t e;
    @(negedge clk);
    A       = a;
    B       = b;
    ALU_Sel = sel;
    e.out   = exp_out;
    e.carry = exp_carry;
    e.zero  = exp_zero;
    e.name  = name;
    sb_q.push_back(e);
  endtask

  // Monitor: one registered result per rising edge, sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0 && !rst) begin
        e = sb_q.pop_front();
        checkOutput(e.name, e.out, e.carry, e.zero);
      end
    end
  end

  initial begin
    exp_t e;
    int   wait_cycles;

    rst     = 1'b1;
    A       = 8'h04;
    B       = 8'h02;
    ALU_Sel = 3'b000;
    #1;
    checkOutput("reset_immediate", 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_held_over_edges", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("reset_hold_after_release", 8'h00, 1'b0, 1'b0);

    // Sweep with A=04, B=02; the first entry is also the first edge after reset release.
    applyStimulus(8'h04, 8'h02, 3'b000, 8'h06, 1'b0, 1'b0, "sweep_add");
    applyStimulus(8'h04, 8'h02, 3'b001, 8'h02, 1'b0, 1'b0, "sweep_sub");
    applyStimulus(8'h04, 8'h02, 3'b010, 8'h08, 1'b0, 1'b0, "sweep_mul");
    applyStimulus(8'h04, 8'h02, 3'b011, 8'h02, 1'b0, 1'b0, "sweep_div");
    applyStimulus(8'h04, 8'h02, 3'b100, 8'h08, 1'b0, 1'b0, "sweep_shl");
    applyStimulus(8'h04, 8'h02, 3'b101, 8'h02, 1'b0, 1'b0, "sweep_shr");
    applyStimulus(8'h04, 8'h02, 3'b110, 8'h00, 1'b0, 1'b1, "sweep_and");
    applyStimulus(8'h04, 8'h02, 3'b111, 8'h06, 1'b0, 1'b0, "sweep_xor");

    applyStimulus(8'hFF, 8'h01, 3'b000, 8'h00, 1'b1, 1'b1, "add_carry_zero");
    applyStimulus(8'h80, 8'h7F, 3'b000, 8'hFF, 1'b0, 1'b0, "add_no_carry");
    applyStimulus(8'h02, 8'h04, 3'b001, 8'hFE, 1'b1, 1'b0, "sub_borrow");
    applyStimulus(8'h05, 8'h05, 3'b001, 8'h00, 1'b0, 1'b1, "sub_equal");
    applyStimulus(8'h10, 8'h10, 3'b010, 8'h00, 1'b1, 1'b1, "mul_overflow_zero");
    applyStimulus(8'h20, 8'h09, 3'b010, 8'h20, 1'b1, 1'b0, "mul_overflow");
    applyStimulus(8'h0F, 8'h11, 3'b010, 8'hFF, 1'b0, 1'b0, "mul_max_no_overflow");
    applyStimulus(8'h37, 8'h00, 3'b011, 8'hFF, 1'b1, 1'b0, "div_by_zero");
    applyStimulus(8'hFF, 8'h10, 3'b011, 8'h0F, 1'b0, 1'b0, "div_truncate");
    applyStimulus(8'h03, 8'h07, 3'b011, 8'h00, 1'b0, 1'b1, "div_small");
    applyStimulus(8'h81, 8'h55, 3'b100, 8'h02, 1'b1, 1'b0, "shl_edge");
    applyStimulus(8'h01, 8'hAA, 3'b101, 8'h00, 1'b1, 1'b1, "shr_edge");
    applyStimulus(8'hF0, 8'h3C, 3'b110, 8'h30, 1'b0, 1'b0, "and_pattern");
    applyStimulus(8'hA5, 8'hA5, 3'b111, 8'h00, 1'b0, 1'b1, "xor_self_zero");

    // Mid-stream reset: issue ADD, then reset between edges while MUL is being set up.
    applyStimulus(8'h04, 8'h02, 3'b000, 8'h06, 1'b0, 1'b0, "pre_reset_add");
    @(posedge clk);
    #2;
    ALU_Sel = 3'b001;
    rst     = 1'b1;
    #1;
    checkOutput("reset_mid_stream", 8'h00, 1'b0, 1'b0);
    rst     = 1'b0;
    ALU_Sel = 3'b010;
    #1;
    checkOutput("reset_mid_release_hold", 8'h00, 1'b0, 1'b0);
    e.out   = 8'h08;
    e.carry = 1'b0;
    e.zero  = 1'b0;
    e.name  = "post_reset_mul";
    sb_q.push_back(e);
    @(posedge clk);

    applyStimulus(8'h04, 8'h02, 3'b111, 8'h06, 1'b0, 1'b0, "post_reset_xor");

    wait_cycles = 0;
    while (sb_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (sb_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain: %0d results still pending, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
